// File: rtl/axi_stream_slave.sv
// Responder for the simplified AR/R + AW/W/B channel set.
// Owns a small register file, accepts fixed-length write bursts and
// returns fixed-length read bursts. Burst addresses wrap modulo the depth.
// Every handshake output is decoded from the registered state only, so
// no input has a combinational path to an output.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for an address; read wins if AR and AW arrive together
// RD_DATA | presenting mem[ptr] on r_data, one beat per r_valid & r_ready
// WR_DATA | storing w_data at mem[ptr], one beat per w_valid & w_ready
// WR_RESP | holding b_valid until the master takes the response
module axi_stream_slave #(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 3,
    parameter int BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic [ADDR_W-1:0] ar_addr,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [DATA_W-1:0] r_data,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DATA_W-1:0] w_data,
    output logic              b_valid,
    input  logic              b_ready,
    output logic              busy,
    output logic [7:0]        wr_bursts,
    output logic [7:0]        rd_bursts
);

    localparam int DEPTH = 1 << ADDR_W;
    // BURST_LEN never exceeds the depth, so the beat counter fits in ADDR_W bits.
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_DATA = 2'd1,
        WR_DATA = 2'd2,
        WR_RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   r_data_q, r_data_d;
    logic [7:0]          wr_bursts_q, wr_bursts_d;
    logic [7:0]          rd_bursts_q, rd_bursts_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [ADDR_W-1:0]   ptr_inc;

    // Pointer advance wraps naturally at the address width.
    assign ptr_inc = ptr_q + ADDR_W'(1);

    // Next-state, datapath and counter updates; everything holds by default.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        r_data_d    = r_data_q;
        wr_bursts_d = wr_bursts_q;
        rd_bursts_d = rd_bursts_q;
        mem_d       = mem_q;
        case (state_q)
            IDLE: begin
                if (ar_valid) begin
                    ptr_d    = ar_addr;
                    cnt_d    = '0;
                    r_data_d = mem_q[ar_addr];
                    state_d  = RD_DATA;
                end else if (aw_valid) begin
                    ptr_d   = aw_addr;
                    cnt_d   = '0;
                    state_d = WR_DATA;
                end
            end
            RD_DATA: begin
                if (r_ready) begin
                    ptr_d    = ptr_inc;
                    cnt_d    = cnt_q + ADDR_W'(1);
                    r_data_d = mem_q[ptr_inc];
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                        if (rd_bursts_q != 8'hFF) begin
                            rd_bursts_d = rd_bursts_q + 8'd1;
                        end
                    end
                end
            end
            WR_DATA: begin
                if (w_valid) begin
                    mem_d[ptr_q] = w_data;
                    ptr_d        = ptr_inc;
                    cnt_d        = cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (b_ready) begin
                    state_d = IDLE;
                    if (wr_bursts_q != 8'hFF) begin
                        wr_bursts_d = wr_bursts_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointers, read data, counters and memory; reset clears everything.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            r_data_q    <= '0;
            wr_bursts_q <= '0;
            rd_bursts_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            r_data_q    <= r_data_d;
            wr_bursts_q <= wr_bursts_d;
            rd_bursts_q <= rd_bursts_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign ar_ready  = (state_q == IDLE);
    assign aw_ready  = (state_q == IDLE);
    assign w_ready   = (state_q == WR_DATA);
    assign b_valid   = (state_q == WR_RESP);
    assign r_valid   = (state_q == RD_DATA);
    assign busy      = (state_q != IDLE);
    assign r_data    = r_data_q;
    assign wr_bursts = wr_bursts_q;
    assign rd_bursts = rd_bursts_q;

endmodule

// File: tb/tb_axi_stream_slave.sv
// Bench for axi_stream_slave: directed bursts, a reference memory model,
// and a read-data scoreboard drained by an independent monitor.
module tb_axi_stream_slave;

    logic       clk;
    logic       rst_n;
    logic       ar_valid, ar_ready;
    logic [2:0] ar_addr;
    logic       r_valid, r_ready;
    logic [3:0] r_data;
    logic       aw_valid, aw_ready;
    logic [2:0] aw_addr;
    logic       w_valid, w_ready;
    logic [3:0] w_data;
    logic       b_valid, b_ready;
    logic       busy;
    logic [7:0] wr_bursts, rd_bursts;

    axi_stream_slave #(.DATA_W(4), .ADDR_W(3), .BURST_LEN(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .b_valid(b_valid), .b_ready(b_ready),
        .busy(busy), .wr_bursts(wr_bursts), .rd_bursts(rd_bursts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] mdl_mem [8];
    int         wr_exp = 0;
    int         rd_exp = 0;
    logic [3:0] exp_rd [$];
    logic       hold_pend = 1'b0;
    logic [3:0] held_data = '0;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // Monitor: pops the expected beat whenever the DUT transfers read data,
    // and verifies r_data is held across a stalled cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (r_valid && hold_pend) check("rd_hold", int'(r_data), int'(held_data));
            hold_pend = r_valid && !r_ready;
            held_data = r_data;
            if (r_valid && r_ready) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected actual=%0d required=none", r_data);
                end else begin
                    check("rd_data", int'(r_data), int'(exp_rd.pop_front()));
                end
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_read(input logic [2:0] addr, input bit toggle);
        int n;
        int cycles;
        int beats;
        for (int i = 0; i < 8; i++) exp_rd.push_back(mdl_mem[(int'(addr) + i) % 8]);
        ar_addr  = addr;
        ar_valid = 1'b1;
        r_ready  = 1'b0;
        n = 0;
        while (!ar_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rd_ar_ready", int'(ar_ready), 1);
        @(posedge clk); #1;
        ar_valid = 1'b0;
        cycles = 0;
        beats  = 0;
        while (beats < 8 && cycles < 100) begin
            r_ready = toggle ? cycles[0] : 1'b1;
            @(negedge clk);
            if (cycles == 0) check("rd_first_valid", int'(r_valid), 1);
            check("rd_aw_ready_low", int'(aw_ready), 0);
            if (r_valid && r_ready) beats++;
            cycles++;
            @(posedge clk); #1;
        end
        r_ready = 1'b0;
        check("rd_beats", beats, 8);
        check("rd_cycles", cycles, toggle ? 16 : 8);
        if (rd_exp < 255) rd_exp++;
        @(negedge clk);
        check("rd_busy_fall", int'(busy), 0);
        check("rd_bursts", int'(rd_bursts), rd_exp);
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [31:0] data, input int stall_len);
        int n;
        int n_wr;
        int beats;
        int stall_cnt;
        aw_addr  = addr;
        aw_valid = 1'b1;
        n = 0;
        while (!aw_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wr_aw_ready", int'(aw_ready), 1);
        @(posedge clk); #1;
        aw_valid = 1'b0;
        n = 0; n_wr = 0; beats = 0; stall_cnt = 0;
        while (n < 100) begin
            w_valid = !(beats == 4 && stall_cnt < stall_len);
            w_data  = data[(beats % 8) * 4 +: 4];
            @(negedge clk);
            if (b_valid) break;
            if (w_ready) n_wr++;
            if (w_valid && w_ready) begin
                mdl_mem[(int'(addr) + beats) % 8] = w_data;
                beats++;
            end else if (w_ready) begin
                stall_cnt++;
            end
            n++;
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
        check("wr_data_cycles", n_wr, 8 + stall_len);
        check("wr_beats", beats, 8);
        b_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("wr_b_hold", int'(b_valid), 1);
        check("wr_bursts_before_b", int'(wr_bursts), wr_exp);
        b_ready = 1'b1;
        @(posedge clk); #1;
        b_ready = 1'b0;
        if (wr_exp < 255) wr_exp++;
        @(negedge clk);
        check("wr_b_done", int'(b_valid), 0);
        check("wr_idle", int'(busy), 0);
        check("wr_bursts", int'(wr_bursts), wr_exp);
    endtask

    initial begin
        rst_n = 1'b1;
        ar_valid = 1'b0; ar_addr = '0; r_ready = 1'b0;
        aw_valid = 1'b0; aw_addr = '0; w_valid = 1'b0; w_data = '0;
        b_ready = 1'b0;
        for (int i = 0; i < 8; i++) mdl_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_ar_ready", int'(ar_ready), 1);
        check("rst_aw_ready", int'(aw_ready), 1);
        check("rst_w_ready", int'(w_ready), 0);
        check("rst_b_valid", int'(b_valid), 0);
        check("rst_r_valid", int'(r_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_r_data", int'(r_data), 0);
        check("rst_wr_bursts", int'(wr_bursts), 0);
        check("rst_rd_bursts", int'(rd_bursts), 0);

        // 1,3,...,15 at address 0, then read them back
        do_write(3'd0, 32'hFDB97531, 0);
        do_read(3'd0, 1'b0);

        // 0,2,...,14 starting at 6 wraps: read from 0 gives 4,6,...,14,0,2
        do_write(3'd6, 32'hECA86420, 0);
        do_read(3'd0, 1'b0);

        // r_ready toggling: 8 beats over 16 cycles with data held on stalls
        do_read(3'd3, 1'b1);

        // w_valid dropped for 3 cycles mid-burst
        do_write(3'd1, 32'h2468ACE1, 3);
        do_read(3'd1, 1'b0);

        // AR and AW together: read goes first, held write follows
        aw_addr  = 3'd5;
        aw_valid = 1'b1;
        do_read(3'd2, 1'b0);
        do_write(3'd5, 32'h13579BDF, 0);
        do_read(3'd5, 1'b0);

        // Reset after 4 write beats: burst discarded, memory and counters cleared
        aw_addr  = 3'd0;
        aw_valid = 1'b1;
        @(posedge clk); #1;
        aw_valid = 1'b0;
        w_valid  = 1'b1;
        w_data   = 4'h7;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        w_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_b_valid", int'(b_valid), 0);
        check("abort_aw_ready", int'(aw_ready), 1);
        check("abort_wr_bursts", int'(wr_bursts), 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) mdl_mem[i] = '0;
        wr_exp = 0;
        rd_exp = 0;
        @(negedge clk);
        check("abort_b_after", int'(b_valid), 0);
        do_read(3'd0, 1'b0);

        // rd_bursts saturation: 256 completed reads leave it at 255
        for (int k = 0; k < 255; k++) do_read(3'(k), 1'b0);
        check("rd_bursts_sat", int'(rd_bursts), 255);

        check("scoreboard_empty", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
